// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: shared types and constants for the Wishbone stream master
package wb_stream_pkg;
  typedef enum logic [1:0] {OP_INSTR = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_ILLEGAL = 2'b11} op_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_ILLEGAL = 2'b10} status_e;
  typedef enum logic [1:0] {IDLE = 2'b00, BUS = 2'b01, RESP = 2'b10} state_e;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam int RESP_W = 34;
  function automatic int cmd_w(input int idx_w);
    return 2 + idx_w + 32;
  endfunction
endpackage

// File: rtl/wb_stream_master.sv
// wb_stream_master: turns a command stream into single Wishbone classic cycles
// and returns one status/data response per command.
module wb_stream_master
  import wb_stream_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int IDX_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [cmd_w(IDX_W)-1:0]   cmd_recv_msg,
  input  logic                      cmd_recv_val,
  output logic                      cmd_recv_rdy,
  output logic [RESP_W-1:0]         resp_send_msg,
  output logic                      resp_send_val,
  input  logic                      resp_send_rdy,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [3:0]                wbm_sel_o,
  output logic [31:0]               wbm_adr_o,
  output logic [31:0]               wbm_dat_o,
  input  logic [31:0]               wbm_dat_i,
  input  logic                      wbm_ack_i,
  output logic                      busy_o
);
  localparam int MW = cmd_w(IDX_W);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cyc_q, cyc_d, we_q, we_d, rv_q, rv_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [RESP_W-1:0] rm_q, rm_d;
  op_e op;
  logic [IDX_W-1:0] idx;
  logic [31:0] win_adr;
  assign op = op_e'(cmd_recv_msg[MW-1 -: 2]);
  assign idx = cmd_recv_msg[32 +: IDX_W];
  assign win_adr = BASE_ADDR + 32'd4 + (32'(idx) << 2);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    we_d = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    rv_d = rv_q;
    rm_d = rm_q;
    case (state_q)
      IDLE: if (cmd_recv_val) begin
        if (op == OP_ILLEGAL) begin
          state_d = RESP;
          rv_d = 1'b1;
          rm_d = {ST_ILLEGAL, 32'h0};
        end else begin
          state_d = BUS;
          cnt_d = '0;
          cyc_d = 1'b1;
          we_d = op != OP_STORE;
          adr_d = op == OP_INSTR ? BASE_ADDR : win_adr;
          dat_d = cmd_recv_msg[31:0];
        end
      end
      BUS: begin
        cnt_d = cnt_q + CW'(1);
        // ack takes priority over an expiring timeout
        if (wbm_ack_i || cnt_q == LAST) begin
          state_d = RESP;
          cyc_d = 1'b0;
          rv_d = 1'b1;
          rm_d = wbm_ack_i ? {ST_OK, we_q ? 32'h0 : wbm_dat_i} : {ST_TIMEOUT, 32'h0};
        end
      end
      RESP: if (resp_send_rdy) begin
        state_d = IDLE;
        rv_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cyc_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      rv_q <= 1'b0;
      rm_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      we_q <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      rv_q <= rv_d;
      rm_q <= rm_d;
    end
  end
  assign cmd_recv_rdy = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_we_o = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign resp_send_val = rv_q;
  assign resp_send_msg = rm_q;
endmodule

// File: tb/tb_wb_stream_master.sv
// tb_wb_stream_master: directed self-checking bench for wb_stream_master
module tb_wb_stream_master;
  logic clk = 1'b0, rst = 1'b1;
  logic [49:0] cmd_msg = '0;
  logic cmd_val = 1'b0, cmd_rdy, resp_val, resp_rdy = 1'b1;
  logic [33:0] resp_msg;
  logic cyc, stb, we, ack = 1'b0, busy;
  logic [3:0] sel;
  logic [31:0] adr, dat_o, dat_i = '0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  wb_stream_master #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_recv_msg(cmd_msg), .cmd_recv_val(cmd_val), .cmd_recv_rdy(cmd_rdy),
    .resp_send_msg(resp_msg), .resp_send_val(resp_val), .resp_send_rdy(resp_rdy),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy_o(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_cyc"}, {62'd0, cyc, stb}, 64'd0);
    check({tag, "_sel"}, 64'(sel), 64'd0);
    check({tag, "_we"}, 64'(we), 64'd0);
    check({tag, "_adr"}, 64'(adr), 64'd0);
    check({tag, "_dat"}, 64'(dat_o), 64'd0);
    check({tag, "_rval"}, 64'(resp_val), 64'd0);
    check({tag, "_rmsg"}, 64'(resp_msg), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rdy"}, 64'(cmd_rdy), 64'd1);
  endtask
  // present a command for one edge; returns at the negedge after acceptance
  task automatic accept(input logic [1:0] op, input logic [15:0] idx, input logic [31:0] data);
    check("cmd_rdy_before", 64'(cmd_rdy), 64'd1);
    cmd_msg = {op, idx, data};
    cmd_val = 1'b1;
    @(negedge clk);
    cmd_val = 1'b0;
  endtask
  task automatic bus_beat(input string tag, input logic exp_we, input logic [31:0] exp_adr, input logic [31:0] exp_dat);
    check({tag, "_cycstb"}, {62'd0, cyc, stb}, 64'd3);
    check({tag, "_sel"}, 64'(sel), 64'hF);
    check({tag, "_we"}, 64'(we), 64'(exp_we));
    check({tag, "_adr"}, 64'(adr), 64'(exp_adr));
    check({tag, "_dat"}, 64'(dat_o), 64'(exp_dat));
  endtask
  task automatic resp_seen(input string tag, input logic [33:0] exp);
    check({tag, "_cyc"}, 64'(cyc), 64'd0);
    check({tag, "_rval"}, 64'(resp_val), 64'd1);
    check({tag, "_rmsg"}, 64'(resp_msg), 64'(exp));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    // stray ack while idle must not do anything
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("stray_ack_rval", 64'(resp_val), 64'd0);
    check("stray_ack_busy", 64'(busy), 64'd0);
    // INSTR, zero-wait slave
    accept(2'b00, 16'h0, 32'hDEAD_BEEF);
    bus_beat("instr", 1'b1, 32'h3000_0000, 32'hDEAD_BEEF);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    resp_seen("instr_resp", {2'b00, 32'h0});
    @(negedge clk);
    check("instr_done_rval", 64'(resp_val), 64'd0);
    check("instr_done_rdy", 64'(cmd_rdy), 64'd1);
    // LOAD idx 5 with 3 wait states
    accept(2'b01, 16'd5, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      bus_beat("load_wait", 1'b1, 32'h3000_0018, 32'h1234_5678);
      @(negedge clk);
    end
    bus_beat("load_ack", 1'b1, 32'h3000_0018, 32'h1234_5678);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    resp_seen("load_resp", {2'b00, 32'h0});
    @(negedge clk);
    // STORE idx 0
    accept(2'b10, 16'd0, 32'h0);
    bus_beat("store", 1'b0, 32'h3000_0004, 32'h0);
    ack = 1'b1;
    dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    ack = 1'b0;
    dat_i = '0;
    resp_seen("store_resp", {2'b00, 32'hCAFE_F00D});
    @(negedge clk);
    // illegal op: no bus cycle, response next cycle
    accept(2'b11, 16'd7, 32'h1111_2222);
    resp_seen("illegal_resp", {2'b10, 32'h0});
    @(negedge clk);
    // timeout: stb high exactly 4 cycles
    accept(2'b00, 16'h0, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) begin
      bus_beat("tmo_beat", 1'b1, 32'h3000_0000, 32'hA5A5_A5A5);
      @(negedge clk);
    end
    resp_seen("tmo_resp", {2'b01, 32'h0});
    @(negedge clk);
    // ack coincident with the last timeout cycle wins
    accept(2'b10, 16'hFFFF, 32'h0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    bus_beat("coinc", 1'b0, 32'h3004_0000, 32'h0);
    ack = 1'b1;
    dat_i = 32'h0BAD_F00D;
    @(negedge clk);
    ack = 1'b0;
    dat_i = '0;
    resp_seen("coinc_resp", {2'b00, 32'h0BAD_F00D});
    @(negedge clk);
    // backpressure: response held, no new command accepted
    resp_rdy = 1'b0;
    accept(2'b10, 16'd1, 32'h0);
    ack = 1'b1;
    dat_i = 32'h0000_55AA;
    @(negedge clk);
    ack = 1'b0;
    dat_i = '0;
    cmd_msg = {2'b00, 16'h0, 32'h7777_7777};
    cmd_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      resp_seen("bp_hold", {2'b00, 32'h0000_55AA});
      check("bp_cmd_rdy", 64'(cmd_rdy), 64'd0);
      @(negedge clk);
    end
    cmd_val = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_rval", 64'(resp_val), 64'd0);
    check("bp_release_cyc", 64'(cyc), 64'd0);
    // asynchronous reset during BUS
    accept(2'b01, 16'd2, 32'h5555_AAAA);
    bus_beat("rst_bus", 1'b1, 32'h3000_000C, 32'h5555_AAAA);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_rval", 64'(resp_val), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
